plot_scheduler: RTL
===================

Name: plot_scheduler

Overview:
- Shares the single VGA adapter plot port between pixel requesters: players 1-4, the timer bar, and a built-in full-screen clear sweep.
- Replaces the fixed five-state draw rotation. Requesters are serviced only when they have a pixel, using work-conserving round-robin.
- Clear sweep runs at game reset and on end-of-round. Outputs drive vga_adapter x/y/colour/plot directly.

Parameters:
- N_REQ, 5, number of requesters (index 0-3 = players, 4 = timer)
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels
- XW, 8, x coordinate width
- YW, 7, y coordinate width

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester pixel request, level, held until granted
- req_x  in  N_REQ*XW  packed x per requester; requester i uses bits [i*XW +: XW]
- req_y  in  N_REQ*YW  packed y per requester
- req_colour  in  N_REQ*3  packed colour per requester
- gnt  out  N_REQ  one-hot grant pulse, one cycle
- clear_start  in  1  pulse; starts a clear sweep
- clear_colour  in  3  fill colour, sampled on clear_start
- busy  out  1  high while the clear sweep runs
- x  out  XW  plot x
- y  out  YW  plot y
- colour  out  3  plot colour
- plot  out  1  write strobe to vga_adapter
- drop_err  out  1  one-cycle pulse when a granted pixel is out of range

Behaviour:
- Reset (async, resetn=0): gnt=0, plot=0, x=0, y=0, colour=0, busy=0, drop_err=0, state=ARB, rr_ptr=N_REQ-1 so the first search starts at index 0, sweep counters=0. Reset asserted mid-sweep aborts the sweep immediately; nothing resumes.
- States:
  - ARB: each cycle, search req starting at (rr_ptr+1) mod N_REQ, wrapping. The first set bit i wins.
  - On a win: gnt[i]=1 combinationally in that cycle; capture req_x/y/colour[i]; rr_ptr<=i.
  - No req set: gnt=0, rr_ptr unchanged, plot=0 next cycle.
  - CLEAR: entered from ARB when clear_start=1. clear_start has priority over any req in that same cycle; no gnt is issued.
- Latency: plot/x/y/colour are registered and appear exactly 1 cycle after gnt. Throughput is 1 pixel/cycle with back-to-back grants.
- Handshake:
  - Requester holds req and its data stable until it sees gnt.
  - In the cycle after gnt it may present a new pixel with req still high; that pixel competes normally.
  - A requester never sees two consecutive grants while another req is pending.
- Range check: a captured pixel with x>=WIDTH or y>=HEIGHT is consumed (gnt still pulses) but plot stays 0. drop_err pulses in the output cycle.
- CLEAR sweep:
  - busy=1 from the cycle after clear_start.
  - Emits plot=1 each cycle with colour=clear_colour (latched), x incrementing 0..WIDTH-1, y incrementing on x wrap, 0..HEIGHT-1.
  - Takes exactly WIDTH*HEIGHT = 19200 plot cycles.
  - The cycle after pixel (WIDTH-1, HEIGHT-1) is plotted: busy=0, return to ARB, rr_ptr unchanged.
  - gnt=0 throughout; pending reqs wait.
  - clear_start during CLEAR is ignored.
- Width rules: sweep x counter XW bits, y counter YW bits. Comparisons are unsigned. rr_ptr is ceil(log2(N_REQ)) bits with explicit wrap at N_REQ-1, not a power-of-two wrap.

Decomposition:
- Shared package: WIDTH, HEIGHT, XW, YW, N_REQ, REQ_P1..REQ_P4, REQ_TIMER index constants, state encodings ARB/CLEAR.
- One sub-module: rr_arbiter (req, rr_ptr -> one-hot gnt, winner index), purely combinational, reusable for the RAM port.
- Sweep counters and output registers stay in plot_scheduler.

Test Plan:
- Reset release, req=5'b00000 for 10 cycles -> plot=0, gnt=0 every cycle, busy=0.
- req=5'b11111 held, all in range -> gnt sequence 0,1,2,3,4,0... one per cycle; plot data matches the granted requester 1 cycle later.
- Only req[2]=1 with x=10,y=20,colour=3'b100, held 3 cycles -> gnt[2] each cycle; plot=1 with (10,20,100) on cycles 2-4.
- req[0] with x=160,y=5 -> gnt[0] pulses, plot=0, drop_err=1 next cycle; same for x=3,y=120.
- clear_start with clear_colour=3'b000 while req[1]=1 -> no gnt for 19200+1 cycles; plots cover (0,0)..(159,119) in raster order; busy falls; gnt[1] on the next cycle.
- resetn low at sweep pixel 5000 -> all outputs 0 asynchronously; after release, state=ARB and the first grant goes to the lowest pending index.

Source files
------------

// File: rtl/plot_scheduler_pkg.sv
// Shared constants and state encoding for the VGA plot-port scheduler.
package plot_scheduler_pkg;

    localparam int unsigned REQ_P1    = 0;
    localparam int unsigned REQ_P2    = 1;
    localparam int unsigned REQ_P3    = 2;
    localparam int unsigned REQ_P4    = 3;
    localparam int unsigned REQ_TIMER = 4;
    localparam int unsigned N_REQ     = REQ_TIMER + 1;

    localparam int unsigned WIDTH  = 160;
    localparam int unsigned HEIGHT = 120;
    localparam int unsigned XW     = 8;
    localparam int unsigned YW     = 7;
    localparam int unsigned CW     = 3;
    localparam int unsigned PTR_W  = $clog2(N_REQ);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/plot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past rr_ptr and wraps at N_REQ-1.
module rr_arbiter
    import plot_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    localparam int unsigned SW = PTR_W + 1;

    logic [SW-1:0]    sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k + 1);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the vga_adapter plot port between players/timer and a full-screen clear sweep.
module plot_scheduler
    import plot_scheduler_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*XW-1:0]   req_x,
    input  logic [N_REQ*YW-1:0]   req_y,
    input  logic [N_REQ*CW-1:0]   req_colour,
    output logic [N_REQ-1:0]      gnt,
    input  logic                  clear_start,
    input  logic [CW-1:0]         clear_colour,
    output logic                  busy,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [CW-1:0]         colour,
    output logic                  plot,
    output logic                  drop_err
);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [XW-1:0]    sx_q, sx_d;
    logic [YW-1:0]    sy_q, sy_d;
    logic [CW-1:0]    clr_col_q, clr_col_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [CW-1:0]    col_q, col_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_win;
    logic             arb_valid;
    logic [XW-1:0]    sel_x;
    logic [YW-1:0]    sel_y;
    logic [CW-1:0]    sel_col;
    logic             sel_in_range;
    logic             sweep_last;
    logic             sweep_x_last;

    rr_arbiter u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (arb_gnt),
        .winner (arb_win),
        .valid  (arb_valid)
    );

    assign sel_x        = req_x[32'(arb_win) * XW +: XW];
    assign sel_y        = req_y[32'(arb_win) * YW +: YW];
    assign sel_col      = req_colour[32'(arb_win) * CW +: CW];
    assign sel_in_range = (sel_x < XW'(WIDTH)) && (sel_y < YW'(HEIGHT));
    assign sweep_x_last = (sx_q == XW'(WIDTH - 1));
    assign sweep_last   = sweep_x_last && (sy_q == YW'(HEIGHT - 1));

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear_start beats any pending request
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (clear_start) state_d = CLEAR;
            CLEAR:   if (sweep_last)  state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Grant, sweep counters and next values of the registered plot outputs
    always_comb begin
        gnt       = '0;
        rr_ptr_d  = rr_ptr_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        clr_col_d = clr_col_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        plot_d    = 1'b0;
        drop_d    = 1'b0;
        busy_d    = (state_d == CLEAR);
        case (state_q)
            ARB: begin
                if (clear_start) begin
                    clr_col_d = clear_colour;
                    sx_d      = '0;
                    sy_d      = '0;
                    x_d       = '0;
                    y_d       = '0;
                    col_d     = clear_colour;
                    plot_d    = 1'b1;
                end else if (arb_valid && resetn) begin
                    gnt      = arb_gnt;
                    rr_ptr_d = arb_win;
                    x_d      = sel_x;
                    y_d      = sel_y;
                    col_d    = sel_col;
                    plot_d   = sel_in_range;
                    drop_d   = !sel_in_range;
                end
            end
            CLEAR: begin
                if (sweep_last) begin
                    sx_d = '0;
                    sy_d = '0;
                end else begin
                    if (sweep_x_last) begin
                        sx_d = '0;
                        sy_d = sy_q + YW'(1);
                    end else begin
                        sx_d = sx_q + XW'(1);
                    end
                    x_d    = sx_d;
                    y_d    = sy_d;
                    col_d  = clr_col_q;
                    plot_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q  <= PTR_W'(N_REQ - 1);
            sx_q      <= '0;
            sy_q      <= '0;
            clr_col_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col_q     <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            clr_col_q <= clr_col_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign colour   = col_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign drop_err = drop_q;

endmodule
